// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state type and default operand width for alu_seq.
// Rev 1.0
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH_DEF = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_iter_core.sv
// alu_iter_core: shared shift/accumulate datapath for iterative MUL and DIV.
// Optional macro ALU_DIV_EN adds the restoring divider. Rev 1.0
`default_nettype none

module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
`ifdef ALU_DIV_EN
  input  logic               is_div,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] res_d
);

  localparam int CW = $clog2(WIDTH);

  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
`ifdef ALU_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     div_trial;
`endif

  always_comb begin
    mul_add = acc_q[0] ? m_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    res_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    div_d     = div_q;
    if (div_q) begin
      // a borrow means the trial subtract failed: keep the shifted remainder
      if (div_trial[WIDTH]) res_d = {acc_q[2*WIDTH-2:0], 1'b0};
      else                  res_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`endif
    acc_d = acc_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
`ifdef ALU_DIV_EN
      div_d = is_div;
      m_d   = is_div ? b : a;
      acc_d = {{WIDTH{1'b0}}, (is_div ? a : b)};
`else
      m_d   = a;
      acc_d = {{WIDTH{1'b0}}, b};
`endif
    end else if (step) begin
      acc_d = res_d;
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign last = step && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      cnt_q <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
`ifdef ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: handshaked add/sub/mul/div ALU; MUL/DIV iterate WIDTH cycles.
// Optional macro ALU_DIV_EN enables the divider. Rev 1.0
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic               err
);

  alu_state_e         state_q, state_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               accept, load, step, last;
  logic [2*WIDTH-1:0] core_res;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] sub_diff;

  assign accept = start && (state_q != ITER);
  assign step   = (state_q == ITER);

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
`ifdef ALU_DIV_EN
    .is_div(op == ALU_DIV),
`endif
    .a     (a),
    .b     (b),
    .last  (last),
    .res_d (core_res)
  );

  always_comb begin
    add_sum  = {1'b0, a} + {1'b0, b};
    // 2*WIDTH-bit subtract gives the sign extension of a negative result for free
    sub_diff = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = err_q;
    y_d      = y_q;
    load     = 1'b0;
    case (state_q)
      ITER: begin
        if (last) begin
          y_d     = core_res;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          case (op)
            ALU_ADD: begin
              y_d     = {{(WIDTH-1){1'b0}}, add_sum};
              err_d   = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
            ALU_SUB: begin
              y_d     = sub_diff;
              err_d   = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
            ALU_MUL: begin
              load    = 1'b1;
              state_d = ITER;
            end
            default: begin
`ifdef ALU_DIV_EN
              if (b == '0) begin
                y_d     = {a, {WIDTH{1'b1}}};
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
              end else begin
                load    = 1'b1;
                state_d = ITER;
              end
`else
              y_d     = '0;
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = DONE;
`endif
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q == ITER);
  assign done = done_q;
  assign err  = err_q;
  assign y    = y_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against an arithmetic model.
// Honours ALU_DIV_EN the same way as the design. Rev 1.0
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op    = 2'b00;
  logic [W-1:0]     a     = '0;
  logic [W-1:0]     b     = '0;
  logic             busy, done, err;
  logic [2*W-1:0]   y;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [2*W-1:0]   exp_y    = '0;
  logic             exp_err  = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .y    (y),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result, error flag and cycles-to-done straight from the arithmetic definition
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                       output logic [2*W-1:0] ry, output logic re, output int lat);
    logic [2*W-1:0] xx, zz;
    xx  = {{W{1'b0}}, x};
    zz  = {{W{1'b0}}, z};
    re  = 1'b0;
    lat = 0;
    case (o)
      ALU_ADD: ry = xx + zz;
      ALU_SUB: ry = xx - zz;
      ALU_MUL: begin ry = xx * zz; lat = W; end
      default: begin
`ifdef ALU_DIV_EN
        if (z == '0) begin
          ry = {x, {W{1'b1}}};
          re = 1'b1;
        end else begin
          ry  = {x % z, x / z};
          lat = W;
        end
`else
        ry = '0;
        re = 1'b1;
`endif
      end
    endcase
  endtask

  // Called just after a clock edge with the DUT free to accept
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                       input int gap, input bit junk);
    logic [2*W-1:0] ry;
    logic           re;
    int             lat;
    model(o, x, z, ry, re, lat);
    start = 1'b1; op = o; a = x; b = z;
    tick();
    start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    if (lat == 0) begin
      check_eq("e0_done", done, 1);
      check_eq("e0_busy", busy, 0);
      check_eq("e0_y",    y,    ry);
      check_eq("e0_err",  err,  re);
    end else begin
      check_eq("e0_busy",   busy, 1);
      check_eq("e0_done",   done, 0);
      check_eq("e0_y_hold", y,    exp_y);
      for (int k = 1; k <= lat; k++) begin
        if (junk) begin
          start = 1'b1; op = 2'($urandom); a = 1; b = 1;
        end
        tick();
        start = 1'b0;
        if (k < lat) begin
          check_eq("iter_busy",     busy, 1);
          check_eq("iter_done",     done, 0);
          check_eq("iter_y_hold",   y,    exp_y);
          check_eq("iter_err_hold", err,  exp_err);
        end else begin
          check_eq("fin_done", done, 1);
          check_eq("fin_busy", busy, 0);
          check_eq("fin_y",    y,    ry);
          check_eq("fin_err",  err,  re);
        end
      end
    end
    exp_y   = ry;
    exp_err = re;
    for (int g = 0; g < gap; g++) begin
      tick();
      check_eq("idle_done",   done, 0);
      check_eq("idle_busy",   busy, 0);
      check_eq("idle_y_hold", y,    exp_y);
      check_eq("idle_err",    err,  exp_err);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // reset held with start high must leave everything cleared
    start = 1'b1; op = ALU_ADD; a = 8'hAA; b = 8'h55;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_y",    y,    0);
    check_eq("rst_err",  err,  0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    do_op(ALU_ADD, 8'd1, 8'd3, 0, 0);
    check_eq("add_1_3", y, 16'd4);
    do_op(ALU_ADD, 8'd255, 8'd255, 1, 0);
    check_eq("add_carry", y, 16'h01FE);
    do_op(ALU_SUB, 8'd3, 8'd5, 1, 0);
    check_eq("sub_3_5", y, 16'hFFFE);
    do_op(ALU_SUB, 8'd3, 8'd1, 0, 0);
    check_eq("sub_3_1", y, 16'd2);
    do_op(ALU_MUL, 8'd255, 8'd255, 0, 1);
    check_eq("mul_ff_ff", y, 16'hFE01);
    do_op(ALU_DIV, 8'd200, 8'd7, 1, 0);
`ifdef ALU_DIV_EN
    check_eq("div_200_7", y, 16'h041C);
    check_eq("div_err", err, 0);
`else
    check_eq("div_off_y", y, 16'h0000);
    check_eq("div_off_err", err, 1);
`endif
    do_op(ALU_DIV, 8'd200, 8'd0, 0, 0);
`ifdef ALU_DIV_EN
    check_eq("div0_y", y, 16'hC8FF);
`else
    check_eq("div0_y", y, 16'h0000);
`endif
    check_eq("div0_err", err, 1);

    // back-to-back accepts in the DONE cycle
    do_op(ALU_MUL, 8'd13, 8'd11, 0, 0);
    do_op(ALU_ADD, 8'd100, 8'd200, 0, 0);
    check_eq("b2b_add", y, 16'd300);
    do_op(ALU_SUB, 8'd0, 8'd1, 0, 0);
    check_eq("b2b_done_high", done, 1);
    check_eq("b2b_sub", y, 16'hFFFF);
    do_op(ALU_ADD, 8'd0, 8'd0, 1, 0);

    // reset asserted after E4 of a multiply aborts it
    start = 1'b1; op = ALU_MUL; a = 8'd9; b = 8'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_eq("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_y",    y,    0);
    check_eq("abort_err",  err,  0);
    repeat (6) begin
      tick();
      check_eq("abort_no_done", done, 0);
    end
    #2 rst_n = 1'b1;
    tick();
    exp_y = '0; exp_err = 1'b0;
    check_eq("post_abort_y", y, 0);

    for (int i = 0; i < 300; i++) begin
      do_op(2'($urandom), pick(), pick(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
